// File: rtl/counter_arbiter.sv
// counter_arbiter: shares one load/enable counter between NREQ requesters.
// Each requester issues a load or a count-N command. Commands are arbitrated
// round-robin and the counter's load/enable strobes are sequenced for the
// winner, which then receives a one-cycle done pulse with the counter value.
// Optional feature macro: COUNTER_ARB_FIXED_PRIO_EN selects fixed priority
// (lowest index wins) and removes the round-robin pointer.
module counter_arbiter #(
  parameter int unsigned NREQ  = 4,
  parameter int unsigned WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  ena,
  input  logic [NREQ-1:0]       req,
  input  logic [NREQ-1:0]       req_load,
  input  logic [NREQ*WIDTH-1:0] req_data,
  output logic [NREQ-1:0]       gnt,
  output logic [NREQ-1:0]       done,
  output logic [WIDTH-1:0]      result,
  output logic                  busy,
  output logic                  cnt_load,
  output logic [WIDTH-1:0]      cnt_data,
  output logic                  cnt_en,
  input  logic [WIDTH-1:0]      cnt_value
);

  localparam int unsigned PW = (NREQ > 1) ? $clog2(NREQ) : 1;

  typedef enum logic [1:0] {StIdle, StLoad, StCount, StDone} state_e;

  state_e            r_state, w_state_next;
  logic [NREQ-1:0]   r_gnt;
  logic [WIDTH-1:0]  r_data;
  logic [WIDTH-1:0]  r_rem;

  logic              w_found;
  logic [PW-1:0]     w_win;
  logic [NREQ-1:0]   w_win_oh;
  logic              w_grant;
  logic [WIDTH-1:0]  w_win_data;

`ifdef COUNTER_ARB_FIXED_PRIO_EN
  // Fixed priority: scan from the top so the lowest requesting index wins last.
  always_comb begin
    w_found = 1'b0;
    w_win   = '0;
    for (int i = int'(NREQ) - 1; i >= 0; i--) begin
      if (req[i]) begin
        w_found = 1'b1;
        w_win   = PW'(i);
      end
    end
  end
`else
  logic [PW-1:0] r_ptr;

  // Round-robin search starting at the pointer, wrapping modulo NREQ.
  always_comb begin
    int unsigned idx;
    w_found = 1'b0;
    w_win   = '0;
    idx     = 0;
    for (int unsigned k = 0; k < NREQ; k++) begin
      idx = 32'(r_ptr) + k;
      if (idx >= NREQ) idx = idx - NREQ;
      if (!w_found && req[idx[PW-1:0]]) begin
        w_found = 1'b1;
        w_win   = idx[PW-1:0];
      end
    end
  end

  // Pointer moves just past each winner so it becomes lowest priority next.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_ptr <= '0;
    end else if (w_grant) begin
      r_ptr <= (w_win == PW'(NREQ - 1)) ? '0 : w_win + 1'b1;
    end
  end
`endif

  // One-hot form of the winner and its data slice.
  always_comb begin
    w_win_oh        = '0;
    w_win_oh[w_win] = 1'b1;
    w_win_data      = req_data[w_win*WIDTH +: WIDTH];
  end

  assign w_grant = (r_state == StIdle) && ena && w_found;

  // Next state and counter strobes; ena low holds state and forces strobes off.
  always_comb begin
    w_state_next = r_state;
    cnt_load     = 1'b0;
    cnt_en       = 1'b0;
    cnt_data     = '0;
    done         = '0;
    result       = '0;
    case (r_state)
      StIdle: begin
        if (w_grant) w_state_next = req_load[w_win] ? StLoad : StCount;
      end
      StLoad: begin
        cnt_data = r_data;
        if (ena) begin
          cnt_load     = 1'b1;
          w_state_next = StDone;
        end
      end
      StCount: begin
        if (ena) begin
          if (r_rem != '0) cnt_en = 1'b1;
          else             w_state_next = StDone;
        end
      end
      StDone: begin
        if (ena) begin
          done         = r_gnt;
          result       = cnt_value;
          w_state_next = StIdle;
        end
      end
      default: w_state_next = StIdle;
    endcase
  end

  // State, latched command and grant; the command is frozen once granted.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= StIdle;
      r_gnt   <= '0;
      r_data  <= '0;
      r_rem   <= '0;
    end else begin
      r_state <= w_state_next;
      if (w_grant) begin
        r_gnt  <= w_win_oh;
        r_data <= w_win_data;
        r_rem  <= w_win_data;
      end else if (ena && (r_state == StCount) && (r_rem != '0)) begin
        r_rem <= r_rem - 1'b1;
      end else if (ena && (r_state == StDone)) begin
        r_gnt <= '0;
      end
    end
  end

  assign gnt  = r_gnt;
  assign busy = (r_state != StIdle);

endmodule
